alu: RTL and testbench
======================

Name: alu

Overview:
- 32-bit integer ALU for the CPU execute stage.
- Performs the arithmetic, logic, shift and compare operation selected by a 4-bit op code on two operands.
- Also produces branch-condition flags.
- Result and flags are registered: one-cycle latency, with asynchronous reset.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported; the shift amount is log2(XLEN) = 5 bits.

Ports:
- clk  in  1  system clock, rising edge active
- rst  in  1  asynchronous, active-high reset
- srca  in  32  operand A
- srcb  in  32  operand B; srcb[4:0] is the shift amount for shift ops
- cntl  in  4  operation select
- not_s  in  1  compare mode for cnd: 1 = unsigned, 0 = signed
- resalt  out  32  registered operation result
- cnd  out  2  registered condition flags: cnd[0] = equal, cnd[1] = less-than

Behaviour:
- Reset: while rst = 1 (asserted asynchronously), resalt = 0 and cnd = 2'b00. Reset is released synchronously to the next rising clk edge.
- Latency: inputs are sampled on each rising clk edge. resalt and cnd reflect those inputs after that edge (1 cycle). No handshake; a new op is accepted every cycle.
- Op codes (cntl):
  - 0000 ADD: A + B, modulo 2^32; carry discarded.
  - 0001 SLT: 1 if A < B as signed, else 0; zero-extended.
  - 0010 SLTU: 1 if A < B as unsigned, else 0.
  - 0011 AND: A & B.
  - 0100 OR: A | B.
  - 0101 XOR: A ^ B.
  - 0110 SLL: A << B[4:0], logical.
  - 0111 SRL: A >> B[4:0], zero-fill.
  - 1000 SUB: A - B, modulo 2^32.
  - 1001 SRA: A >> B[4:0], sign-fill from A[31].
  - 1010 AM (add-mask, jump target): (A + B) & 32'hFFFF_FFFE.
  - 1011-1111: resalt = 0.
- Shift amount: only B[4:0] is used; B[31:5] is ignored. A shift of 0 returns A unchanged.
- cnd, computed every cycle independent of cntl:
  - cnd[0] = (A == B).
  - cnd[1] = A < B, unsigned when not_s = 1, signed when not_s = 0.
- SLT/SLTU signedness is fixed by the op code and is not affected by not_s.
- X/undriven inputs: no requirement; outputs may be X.

Decomposition:
- Shared package alu_pkg holds:
  - localparams for the 11 op codes (ADD, SLT, SLTU, AND, OR, XOR, SLL, SRL, SUB, SRA, AM);
  - the AM mask constant;
  - the XLEN constant.
- One natural sub-module: alu_shifter. It is combinational, implements SLL/SRL/SRA, and takes data, shamt[4:0] and a 2-bit shift type.
- The top level contains the adder/subtractor, comparators, result mux and output registers.

Test Plan:
- Reset mid-operation: assert rst with a non-zero result registered -> resalt = 0 and cnd = 00 immediately, without waiting for a clock edge; both stay 0 until after release.
- A = 0x0000000A, B = 0x00000001, not_s = 1, sweep each op:
  - ADD = 0xB, SLT = 0, SLTU = 0, AND = 0, OR = 0xB, XOR = 0xB;
  - SLL = 0x14, SRL = 0x5, SUB = 0x9, SRA = 0x5, AM = 0xA;
  - cnd = 00 on every op, each checked one cycle after apply.
- A = 0x0000FFFA, B = 0x0000FFF1 (shamt = 17), not_s = 1:
  - ADD = 0x0001FFEB, SUB = 0x9, AND = 0xFFF0, OR = 0xFFFB, XOR = 0x000B;
  - SLL = 0xFFF40000, SRL = 0, SRA = 0, AM = 0x0001FFEA;
  - cnd = 00.
- Signedness, A = 0xFFFFFFFF, B = 0x00000001:
  - SLT = 1, SLTU = 0;
  - not_s = 0 -> cnd = 10; not_s = 1 -> cnd = 00.
- Shift edges:
  - A = 0x80000000, B = 4: SRA = 0xF8000000, SRL = 0x08000000.
  - B = 0x00000020 (shamt 0): SLL = A unchanged.
  - A = B = 0x12345678: SUB = 0, cnd[0] = 1.
- Undefined op and pipelining:
  - cntl = 1111 -> resalt = 0.
  - Back-to-back op changes every cycle -> each result appears exactly one cycle after its inputs, with no bubbles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: width, op codes, AM mask, shift types.
package alu_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLT  = 4'b0001;
    localparam logic [3:0] OP_SLTU = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_AM   = 4'b1010;

    // Jump targets are halfword aligned, so AM clears bit 0 of the sum.
    localparam logic [XLEN-1:0] AM_MASK = 32'hFFFF_FFFE;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10
    } shift_type_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter covering logical left, logical right and arithmetic right.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [XLEN-1:0]    data,
    input  logic [SHAMT_W-1:0] shamt,
    input  shift_type_e        shift_type,
    output logic [XLEN-1:0]    shifted
);

    // Select the shift flavour; arithmetic right replicates data[XLEN-1] into vacated bits.
    always_comb begin
        shifted = data;
        case (shift_type)
            SH_SLL:  shifted = data << shamt;
            SH_SRL:  shifted = data >> shamt;
            SH_SRA:  shifted = $unsigned($signed(data) >>> shamt);
            default: shifted = data << shamt;
        endcase
    end

endmodule

// File: rtl/alu.sv
// 32-bit execute-stage ALU with registered result and branch-condition flags.
module alu
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    input  logic [3:0]      cntl,
    input  logic            not_s,
    output logic [XLEN-1:0] resalt,
    output logic [1:0]      cnd
);

    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic            lt_signed;
    logic            lt_unsigned;
    logic [XLEN-1:0] shifted;
    shift_type_e     shift_type;
    logic [XLEN-1:0] result_next;
    logic [1:0]      cnd_next;

    assign sum         = srca + srcb;
    assign diff        = srca - srcb;
    assign lt_signed   = $signed(srca) < $signed(srcb);
    assign lt_unsigned = srca < srcb;

    // Map the op code onto the shifter's shift type; non-shift ops leave it at SLL.
    always_comb begin
        shift_type = SH_SLL;
        case (cntl)
            OP_SRL:  shift_type = SH_SRL;
            OP_SRA:  shift_type = SH_SRA;
            default: shift_type = SH_SLL;
        endcase
    end

    alu_shifter u_shifter (
        .data       (srca),
        .shamt      (srcb[SHAMT_W-1:0]),
        .shift_type (shift_type),
        .shifted    (shifted)
    );

    // Result mux; unused op codes produce zero.
    always_comb begin
        result_next = '0;
        case (cntl)
            OP_ADD:  result_next = sum;
            OP_SLT:  result_next = {{(XLEN-1){1'b0}}, lt_signed};
            OP_SLTU: result_next = {{(XLEN-1){1'b0}}, lt_unsigned};
            OP_AND:  result_next = srca & srcb;
            OP_OR:   result_next = srca | srcb;
            OP_XOR:  result_next = srca ^ srcb;
            OP_SLL:  result_next = shifted;
            OP_SRL:  result_next = shifted;
            OP_SUB:  result_next = diff;
            OP_SRA:  result_next = shifted;
            OP_AM:   result_next = sum & AM_MASK;
            default: result_next = '0;
        endcase
    end

    // Branch flags are independent of the op; not_s picks the less-than signedness.
    always_comb begin
        cnd_next    = 2'b00;
        cnd_next[0] = (srca == srcb);
        cnd_next[1] = not_s ? lt_unsigned : lt_signed;
    end

    // Output registers give the one-cycle latency and clear asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resalt <= '0;
            cnd    <= 2'b00;
        end else begin
            resalt <= result_next;
            cnd    <= cnd_next;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expectations are queued at drive time and popped one cycle later.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [3:0]  cntl;
    logic        not_s;
    logic [31:0] resalt;
    logic [1:0]  cnd;

    int n_compared;
    int n_mismatched;

    string       q_tag[$];
    logic [31:0] q_res[$];
    logic [1:0]  q_cnd[$];

    alu dut (
        .clk    (clk),
        .rst    (rst),
        .srca   (srca),
        .srcb   (srcb),
        .cntl   (cntl),
        .not_s  (not_s),
        .resalt (resalt),
        .cnd    (cnd)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result, written independently of the RTL structure.
    function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        logic [63:0] ext;
        int          sh;
        sh  = int'(b[4:0]);
        ext = {{32{a[31]}}, a} >> sh;
        case (op)
            4'd0:    return a + b;
            4'd1:    return {31'd0, (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)};
            4'd2:    return {31'd0, a < b};
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return a << sh;
            4'd7:    return a >> sh;
            4'd8:    return a + ~b + 32'd1;
            4'd9:    return ext[31:0];
            4'd10:   return {a[31:1] + b[31:1] + {30'd0, a[0] & b[0]}, 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] model_cnd(input logic [31:0] a, input logic [31:0] b,
                                             input logic ns);
        logic lt;
        lt = ns ? (a < b) : ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
        return {lt, a == b};
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        assert (got === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with what the DUT registered.
    task automatic checkOutput();
        string       tag;
        logic [31:0] er;
        logic [1:0]  ec;
        if (q_tag.size() > 0) begin
            tag = q_tag.pop_front();
            er  = q_res.pop_front();
            ec  = q_cnd.pop_front();
            checkValue({tag, ".resalt"}, resalt, er);
            checkValue({tag, ".cnd"}, {30'd0, cnd}, {30'd0, ec});
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op, input logic ns,
                                 input logic [31:0] er, input logic [1:0] ec);
        srca  = a;
        srcb  = b;
        cntl  = op;
        not_s = ns;
        q_tag.push_back(tag);
        q_res.push_back(er);
        q_cnd.push_back(ec);
    endtask

    // One cycle: check what the previous edge registered, then drive the next op.
    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic ns,
                        input logic [31:0] er, input logic [1:0] ec);
        @(negedge clk);
        checkOutput();
        applyStimulus(tag, a, b, op, ns, er, ec);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rop;
        logic        rns;
        n_compared   = 0;
        n_mismatched = 0;
        rst   = 1'b1;
        srca  = 32'h0000_000A;
        srcb  = 32'h0000_0001;
        cntl  = 4'b0000;
        not_s = 1'b1;

        @(posedge clk);
        #1;
        checkValue("reset.resalt", resalt, 32'd0);
        checkValue("reset.cnd", {30'd0, cnd}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Operand pair A=0xA, B=1.
        step("a_add",  32'hA, 32'h1, 4'b0000, 1'b1, 32'hB,  2'b00);
        step("a_slt",  32'hA, 32'h1, 4'b0001, 1'b1, 32'h0,  2'b00);
        step("a_sltu", 32'hA, 32'h1, 4'b0010, 1'b1, 32'h0,  2'b00);
        step("a_and",  32'hA, 32'h1, 4'b0011, 1'b1, 32'h0,  2'b00);
        step("a_or",   32'hA, 32'h1, 4'b0100, 1'b1, 32'hB,  2'b00);
        step("a_xor",  32'hA, 32'h1, 4'b0101, 1'b1, 32'hB,  2'b00);
        step("a_sll",  32'hA, 32'h1, 4'b0110, 1'b1, 32'h14, 2'b00);
        step("a_srl",  32'hA, 32'h1, 4'b0111, 1'b1, 32'h5,  2'b00);
        step("a_sub",  32'hA, 32'h1, 4'b1000, 1'b1, 32'h9,  2'b00);
        step("a_sra",  32'hA, 32'h1, 4'b1001, 1'b1, 32'h5,  2'b00);
        step("a_am",   32'hA, 32'h1, 4'b1010, 1'b1, 32'hA,  2'b00);
        step("a_undef",32'hA, 32'h1, 4'b1111, 1'b1, 32'h0,  2'b00);

        // Operand pair A=0xFFFA, B=0xFFF1 (shamt 17).
        step("b_add", 32'hFFFA, 32'hFFF1, 4'b0000, 1'b1, 32'h0001_FFEB, 2'b00);
        step("b_sub", 32'hFFFA, 32'hFFF1, 4'b1000, 1'b1, 32'h9,         2'b00);
        step("b_and", 32'hFFFA, 32'hFFF1, 4'b0011, 1'b1, 32'hFFF0,      2'b00);
        step("b_or",  32'hFFFA, 32'hFFF1, 4'b0100, 1'b1, 32'hFFFB,      2'b00);
        step("b_xor", 32'hFFFA, 32'hFFF1, 4'b0101, 1'b1, 32'h000B,      2'b00);
        step("b_sll", 32'hFFFA, 32'hFFF1, 4'b0110, 1'b1, 32'hFFF4_0000, 2'b00);
        step("b_srl", 32'hFFFA, 32'hFFF1, 4'b0111, 1'b1, 32'h0,         2'b00);
        step("b_sra", 32'hFFFA, 32'hFFF1, 4'b1001, 1'b1, 32'h0,         2'b00);
        step("b_am",  32'hFFFA, 32'hFFF1, 4'b1010, 1'b1, 32'h0001_FFEA, 2'b00);

        // Signedness of SLT/SLTU and of cnd[1].
        step("s_slt_signed",   32'hFFFF_FFFF, 32'h1, 4'b0001, 1'b0, 32'h1, 2'b10);
        step("s_slt_unsigned", 32'hFFFF_FFFF, 32'h1, 4'b0001, 1'b1, 32'h1, 2'b00);
        step("s_sltu_signed",  32'hFFFF_FFFF, 32'h1, 4'b0010, 1'b0, 32'h0, 2'b10);
        step("s_sltu_unsign",  32'hFFFF_FFFF, 32'h1, 4'b0010, 1'b1, 32'h0, 2'b00);

        // Shift and equality edges.
        step("e_sra_msb",  32'h8000_0000, 32'h4,  4'b1001, 1'b1, 32'hF800_0000, 2'b00);
        step("e_srl_msb",  32'h8000_0000, 32'h4,  4'b0111, 1'b1, 32'h0800_0000, 2'b00);
        step("e_sll_sh0",  32'h8000_0000, 32'h20, 4'b0110, 1'b1, 32'h8000_0000, 2'b00);
        step("e_sra_sh0",  32'h8000_0000, 32'h20, 4'b1001, 1'b0, 32'h8000_0000, 2'b10);
        step("e_sub_eq",   32'h1234_5678, 32'h1234_5678, 4'b1000, 1'b1, 32'h0, 2'b01);
        step("e_undef_eq", 32'h1234_5678, 32'h1234_5678, 4'b1111, 1'b0, 32'h0, 2'b01);

        // Back-to-back random ops, expectations from the reference model.
        for (int i = 0; i < 24; i++) begin
            ra  = $urandom;
            rb  = (i % 4 == 0) ? ra : $urandom;
            rop = 4'($urandom_range(0, 15));
            rns = 1'($urandom_range(0, 1));
            step($sformatf("r%0d_op%0d", i, rop), ra, rb, rop, rns,
                 model_res(ra, rb, rop), model_cnd(ra, rb, rns));
        end

        // Reset mid-operation: register a non-zero result, then assert reset between edges.
        step("m_add", 32'hA, 32'h1, 4'b0000, 1'b1, 32'hB, 2'b00);
        step("m_sub", 32'hFFFF_FFFF, 32'h1, 4'b1000, 1'b0, 32'hFFFF_FFFE, 2'b10);
        @(negedge clk);
        checkOutput();
        #2;
        rst = 1'b1;
        #1;
        checkValue("rst_async.resalt", resalt, 32'd0);
        checkValue("rst_async.cnd", {30'd0, cnd}, 32'd0);
        @(posedge clk);
        #1;
        checkValue("rst_hold.resalt", resalt, 32'd0);
        checkValue("rst_hold.cnd", {30'd0, cnd}, 32'd0);
        @(negedge clk);
        checkValue("rst_hold2.resalt", resalt, 32'd0);
        rst = 1'b0;
        applyStimulus("m_after", 32'h5, 32'h7, 4'b0000, 1'b0, 32'hC, 2'b10);
        step("m_tail", 32'h5, 32'h5, 4'b0101, 1'b1, 32'h0, 2'b01);
        @(negedge clk);
        checkOutput();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
